if_stage: RTL and testbench

Instruction-fetch stage, the producer side of the IF→ID pipeline handshake.
- Owns the PC.
- Issues single-outstanding requests to a synchronous instruction memory.
- Holds a returned word in a 1-entry buffer until the downstream IF/ID register accepts it.
- Presents pc_if, instruction_if, valid_if and ready_go_if, and consumes allow_in_id.
- Redirect (jump/flush) from EX reloads the PC and cancels in-flight fetches.

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_pc_reg.sv | 41 ++++
 rtl/if_stage.sv | 133 +++++++++++++
 tb/tb_if_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, the NOP
// encoding and the fetch FSM state encoding.
package if_stage_pkg;

  localparam int IF_BUS_WIDTH  = 32;
  localparam int IF_DATA_WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [31:0] IF_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IF_IDLE   = 3'd0,
    IF_REQ    = 3'd1,
    IF_WAIT   = 3'd2,
    IF_HOLD   = 3'd3,
    IF_CANCEL = 3'd4
  } if_state_e;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: synchronous active-low reset to RESET_PC,
// redirect load takes priority over the +4 increment on transfer.
module if_pc_reg
  import if_stage_pkg::*;
#(
  parameter int                   BUS_WIDTH = IF_BUS_WIDTH,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en,
  input  logic [BUS_WIDTH-1:0] load_addr,
  input  logic                 inc_en,
  output logic [BUS_WIDTH-1:0] pc
);

  logic [BUS_WIDTH-1:0] pc_d;
  logic [BUS_WIDTH-1:0] pc_q;

  // Next PC: redirect wins, otherwise advance one word on transfer (wraps)
  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_addr;
    end else if (inc_en) begin
      pc_d = pc_q + BUS_WIDTH'(4);
    end
  end

  // PC state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to
// a synchronous imem, buffers one returned word until IF/ID accepts it, and
// cancels in-flight fetches on redirect.
// Optional build macro IF_MISALIGN_CHECK_EN: adds misalign_if, loads jump
// targets unmodified and presents a NOP for a misaligned PC instead of fetching.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                   BUS_WIDTH  = IF_BUS_WIDTH,
  parameter int                   DATA_WIDTH = IF_DATA_WIDTH,
  parameter logic [BUS_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_en,
  input  logic [BUS_WIDTH-1:0]  jump_addr,
  output logic                  inst_req,
  output logic [BUS_WIDTH-1:0]  inst_addr,
  input  logic                  inst_gnt,
  input  logic                  inst_rvalid,
  input  logic [DATA_WIDTH-1:0] inst_rdata,
  output logic [BUS_WIDTH-1:0]  pc_if,
  output logic [DATA_WIDTH-1:0] instruction_if,
  output logic                  valid_if,
  output logic                  ready_go_if,
  input  logic                  allow_in_id
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic                  misalign_if
`endif
);

  if_state_e             state_d, state_q;
  logic [DATA_WIDTH-1:0] buf_d, buf_q;
  logic [BUS_WIDTH-1:0]  pc;
  logic [BUS_WIDTH-1:0]  jump_target;
  logic                  misalign_w;
  logic                  transfer;

`ifdef IF_MISALIGN_CHECK_EN
  assign jump_target = jump_addr;
  assign misalign_w  = (state_q == IF_REQ) && (pc[1:0] != 2'b00);
  assign misalign_if = misalign_w;
`else
  // Targets are word aligned; low two bits are dropped on load
  assign jump_target = jump_addr & ~BUS_WIDTH'(3);
  assign misalign_w  = 1'b0;
`endif

  if_pc_reg #(
    .BUS_WIDTH (BUS_WIDTH),
    .RESET_PC  (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (jump_en),
    .load_addr (jump_target),
    .inc_en    (transfer),
    .pc        (pc)
  );

  // Handshake outputs toward imem and IF/ID; a redirect kills this cycle's offer
  always_comb begin
    inst_req       = (state_q == IF_REQ) && !misalign_w;
    inst_addr      = pc;
    pc_if          = pc;
    valid_if       = ((state_q == IF_REQ) || (state_q == IF_WAIT) ||
                      (state_q == IF_HOLD)) && !jump_en;
    ready_go_if    = (((state_q == IF_WAIT) && inst_rvalid) ||
                      (state_q == IF_HOLD) || misalign_w) && !jump_en;
    instruction_if = inst_rdata;
    if (state_q == IF_HOLD) begin
      instruction_if = buf_q;
    end else if (misalign_w) begin
      instruction_if = DATA_WIDTH'(IF_NOP);
    end
    transfer       = valid_if && ready_go_if && allow_in_id;
  end

  // Next-state and buffer update; redirect overrides normal sequencing
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    case (state_q)
      IF_IDLE: state_d = IF_REQ;
      IF_REQ: begin
        if (inst_req && inst_gnt) begin
          state_d = jump_en ? IF_CANCEL : IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (jump_en) begin
          // Response arriving with the redirect is simply discarded
          state_d = inst_rvalid ? IF_REQ : IF_CANCEL;
        end else if (inst_rvalid) begin
          if (allow_in_id) begin
            state_d = IF_REQ;
          end else begin
            buf_d   = inst_rdata;
            state_d = IF_HOLD;
          end
        end
      end
      IF_HOLD: begin
        if (jump_en || allow_in_id) begin
          state_d = IF_REQ;
        end
      end
      IF_CANCEL: begin
        // Exactly one stale response is owed; drop it and refetch
        if (inst_rvalid) begin
          state_d = IF_REQ;
        end
      end
      default: state_d = IF_IDLE;
    endcase
    if (jump_en) begin
      buf_d = '0;
    end
  end

  // FSM state and holding buffer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IF_IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized traffic
// against a behavioural imem and an in-order program-counter reference model.
module tb_if_stage;

  localparam int          BW     = 32;
  localparam int          DW     = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic          clk;
  logic          rst_n;
  logic          jump_en;
  logic [BW-1:0] jump_addr;
  logic          inst_req;
  logic [BW-1:0] inst_addr;
  logic          inst_gnt;
  logic          inst_rvalid;
  logic [DW-1:0] inst_rdata;
  logic [BW-1:0] pc_if;
  logic [DW-1:0] instruction_if;
  logic          valid_if;
  logic          ready_go_if;
  logic          allow_in_id;
`ifdef IF_MISALIGN_CHECK_EN
  logic          misalign_if;
`endif

  if_stage #(
    .BUS_WIDTH  (BW),
    .DATA_WIDTH (DW),
    .RESET_PC   (RST_PC)
  ) dut (
`ifdef IF_MISALIGN_CHECK_EN
    .misalign_if    (misalign_if),
`endif
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_en        (jump_en),
    .jump_addr      (jump_addr),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_gnt       (inst_gnt),
    .inst_rvalid    (inst_rvalid),
    .inst_rdata     (inst_rdata),
    .pc_if          (pc_if),
    .instruction_if (instruction_if),
    .valid_if       (valid_if),
    .ready_go_if    (ready_go_if),
    .allow_in_id    (allow_in_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // imem model and reference state
  logic        outst    = 1'b0;
  int          cnt      = 0;
  logic [31:0] out_addr = '0;
  logic [31:0] exp_pc   = RST_PC;
  int          xfer_cnt = 0;
  int          gnt_pct  = 100;
  int          lat_max  = 0;
  logic        junk     = 1'b0;
  logic        prev_rst = 1'b0;
  logic        s_fire   = 1'b0;
  logic        s_rv     = 1'b0;
  logic [31:0] s_addr   = '0;

  // Memory image: a fixed word at 0x10, a hash of the address elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) + 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge, then sample and score just after
  task automatic step_begin(input logic rst_v, input logic jmp,
                            input logic [31:0] ja, input logic alw);
    @(negedge clk);
    rst_n       = rst_v;
    jump_en     = jmp;
    jump_addr   = ja;
    allow_in_id = alw;
    inst_gnt    = ($urandom_range(99) < gnt_pct);
    inst_rvalid = outst && (cnt == 0);
    inst_rdata  = inst_rvalid ? mem_word(out_addr) : (junk ? $urandom : 32'h0);
    #1;
    s_fire = inst_req && inst_gnt;
    s_addr = inst_addr;
    s_rv   = inst_rvalid;
    if (rst_v) begin
      if (prev_rst) begin
        check("post_reset_valid", 32'(valid_if), 32'h0);
        check("post_reset_req",   32'(inst_req), 32'h0);
      end
      if (inst_req === 1'b1) begin
        check("req_addr",        inst_addr,  exp_pc);
        check("one_outstanding", 32'(outst), 32'h0);
      end
      if (valid_if === 1'b1) check("pc_if", pc_if, exp_pc);
      if ((valid_if & ready_go_if & allow_in_id) === 1'b1) begin
        check("xfer_pc",   pc_if,          exp_pc);
        check("xfer_inst", instruction_if, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        xfer_cnt++;
      end
      if (jmp) exp_pc = ja & ~32'h3;
    end else begin
      exp_pc = RST_PC;
    end
    prev_rst = !rst_v;
  endtask

  // Advance across the active edge and update the imem model
  task automatic step_end();
    @(posedge clk);
    if (!rst_n) begin
      outst = 1'b0;
    end else begin
      if (s_rv) outst = 1'b0;
      else if (outst && cnt > 0) cnt--;
      if (s_fire) begin
        outst    = 1'b1;
        out_addr = s_addr;
        cnt      = $urandom_range(lat_max, 0);
      end
    end
  endtask

  task automatic cycle(input logic rst_v, input logic jmp,
                       input logic [31:0] ja, input logic alw);
    step_begin(rst_v, jmp, ja, alw);
    step_end();
  endtask

  initial begin
    rst_n = 1'b0; jump_en = 1'b0; jump_addr = '0; allow_in_id = 1'b0;
    inst_gnt = 1'b0; inst_rvalid = 1'b0; inst_rdata = '0;

    // Reset state
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    step_begin(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_inst_req",    32'(inst_req),    32'h0);
    check("rst_valid_if",    32'(valid_if),    32'h0);
    check("rst_ready_go_if", 32'(ready_go_if), 32'h0);
    check("rst_instruction", instruction_if,   32'h0);
    check("rst_pc_if",       pc_if,            RST_PC);
    step_end();

    // Zero-wait imem, IF/ID always accepting: PCs 0,4,8 in 7 cycles
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    check("stream_xfer_count", 32'(xfer_cnt), 32'd3);
    check("stream_next_pc",    exp_pc,        32'h0000_000C);

    // Stall: word for 0x10 returns while IF/ID is blocked for 5 cycles
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    step_begin(1'b1, 1'b0, 32'h0, 1'b0);
    check("stall_arrive_ready", 32'(ready_go_if), 32'h1);
    check("stall_arrive_inst",  instruction_if,   32'hDEAD_BEEF);
    step_end();
    for (int i = 0; i < 4; i++) begin
      step_begin(1'b1, 1'b0, 32'h0, 1'b0);
      check("hold_inst",     instruction_if,   32'hDEAD_BEEF);
      check("hold_pc",       pc_if,            32'h0000_0010);
      check("hold_no_req",   32'(inst_req),    32'h0);
      check("hold_ready_go", 32'(ready_go_if), 32'h1);
      step_end();
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect coincident with grant: stale response must be dropped
    step_begin(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    check("jgnt_req_addr", inst_addr,     32'h0000_0014);
    check("jgnt_valid",    32'(valid_if), 32'h0);
    step_end();
    step_begin(1'b1, 1'b0, 32'h0, 1'b1);
    check("cancel_rvalid_seen", 32'(inst_rvalid), 32'h1);
    check("cancel_valid",       32'(valid_if),    32'h0);
    check("cancel_ready_go",    32'(ready_go_if), 32'h0);
    step_end();
    step_begin(1'b1, 1'b0, 32'h0, 1'b1);
    check("jtarget_req",  32'(inst_req), 32'h1);
    check("jtarget_addr", inst_addr,     32'h0000_0200);
    step_end();

    // Redirect coincident with response in WAIT: no transfer, no cancel
    step_begin(1'b1, 1'b1, 32'h0000_0341, 1'b1);
    check("jwait_valid",    32'(valid_if),    32'h0);
    check("jwait_ready_go", 32'(ready_go_if), 32'h0);
    step_end();
    step_begin(1'b1, 1'b0, 32'h0, 1'b1);
    check("jwait_next_req",  32'(inst_req), 32'h1);
    check("jwait_next_addr", inst_addr,     32'h0000_0340);
    step_end();

    // Reset while holding a buffered word
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    step_begin(1'b1, 1'b0, 32'h0, 1'b1);
    check("hold_rst_pc", pc_if, RST_PC);
    step_end();
    step_begin(1'b1, 1'b0, 32'h0, 1'b1);
    check("refetch_req",  32'(inst_req), 32'h1);
    check("refetch_addr", inst_addr,     RST_PC);
    step_end();

    // Randomized traffic: gnt stalls, variable latency, stalls, redirects, resets
    junk    = 1'b1;
    gnt_pct = 70;
    lat_max = 2;
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst;
      logic        r_jmp;
      logic [31:0] r_ja;
      logic        r_alw;
      r_rst = ($urandom_range(199) != 0);
      r_jmp = ($urandom_range(19) == 0);
      r_ja  = $urandom;
      if ($urandom_range(9) == 0) r_ja = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      r_alw = ($urandom_range(3) != 0);
      cycle(r_rst, r_jmp, r_ja, r_alw);
    end
    check("random_progress", 32'(xfer_cnt > 300), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
